// File: rtl/pkt_release_pkg.sv
// Shared definitions for the packet release stage: action codes, FSM states and
// the layout of the 12-bit release command.
package pkt_release_pkg;

  localparam int unsigned CMD_W       = 12;
  localparam int unsigned CMD_ID_LSB  = 0;
  localparam int unsigned CMD_ID_W    = 8;
  localparam int unsigned CMD_ACT_LSB = 8;
  localparam int unsigned CMD_ACT_W   = 4;

  localparam logic [CMD_ACT_W-1:0] ACT_SEND = 4'd0;
  localparam logic [CMD_ACT_W-1:0] ACT_DROP = 4'd1;
  localparam logic [CMD_ACT_W-1:0] ACT_COPY = 4'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    SEND = 2'd2
  } state_e;

  function automatic logic [CMD_ACT_W-1:0] cmd_act(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_ACT_LSB +: CMD_ACT_W];
  endfunction

endpackage

// File: rtl/pkt_release_cmd_fifo.sv
// Synchronous show-ahead command FIFO. A push while full is accepted only when
// a pop happens in the same cycle.
module pkt_release_cmd_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign q       = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pkt_release.sv
// Packet release stage: buffers ingress packets in per-ID slots and streams,
// copies or drops them on release commands, feeding a sop/eop valid-ready egress.
module pkt_release
  import pkt_release_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned SLOT_W    = 4,
  parameter int unsigned MAX_WORDS = 32,
  parameter int unsigned CMDQ_D    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [7:0]        in_id,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pktIDout_valid,
  input  logic [11:0]       pktIDout,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       err_cnt
);

  localparam int unsigned WORD_W = $clog2(MAX_WORDS);
  localparam int unsigned LEN_W  = WORD_W + 1;
  localparam int unsigned NSLOT  = 2 ** SLOT_W;
  localparam int unsigned ADDR_W = SLOT_W + WORD_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  // Ingress state
  logic              in_act_q, trunc_q;
  logic [SLOT_W-1:0] wr_slot_q;
  logic [LEN_W-1:0]  wcnt_q;
  logic [SLOT_W-1:0] wr_slot;
  logic [LEN_W-1:0]  wr_idx, wr_len;
  logic              wr_accept, wr_en, wr_done, trunc_err;

  // Slot bookkeeping
  logic [NSLOT-1:0]  slot_valid_q, slot_valid_d;
  logic [LEN_W-1:0]  len_q [NSLOT];
  logic              free_en;
  logic [SLOT_W-1:0] free_slot;

  // Command queue
  logic [CMD_W-1:0]     cmd_head;
  logic                 cmd_pop, cmd_full, cmd_empty, ovf_err;
  logic [SLOT_W-1:0]    head_slot;
  logic [CMD_ACT_W-1:0] head_act;
  logic                 head_ok, head_sends, pop_start, pop_free, miss_err;

  // Release FSM and egress pipeline
  state_e               state_q;
  logic [CMD_ACT_W-1:0] cur_act_q;
  logic [SLOT_W-1:0]    cur_slot_q;
  logic [LEN_W-1:0]     cur_len_q, rcnt_q;
  logic                 rd_vld_q, rd_sop_q, rd_eop_q;
  logic [DATA_W-1:0]    rd_data_q;
  logic                 skid_valid_q, skid_sop_q, skid_eop_q;
  logic [DATA_W-1:0]    skid_data_q;
  logic                 out_load, out_fire, eop_done, rd_issue_ok, send_issue, issue;
  logic [LEN_W-1:0]     issue_idx, issue_len;
  logic [SLOT_W-1:0]    issue_slot;
  logic                 issue_sop, issue_eop;
  logic [ADDR_W-1:0]    rd_addr;

  logic [DATA_W-1:0] mem [NSLOT * MAX_WORDS];

  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{in_id, cmd_head};

  // ---------------------------------------------------------------------------
  // Ingress: a word belongs to a packet only after a sop has been seen
  always_comb begin
    wr_slot   = in_sop ? in_id[SLOT_W-1:0] : wr_slot_q;
    wr_idx    = in_sop ? '0 : wcnt_q;
    wr_accept = in_valid & (in_sop | in_act_q);
    wr_en     = wr_accept & (wr_idx < MAX_LEN);
    trunc_err = wr_accept & ~wr_en & ~trunc_q;
    wr_done   = wr_accept & in_eop;
    wr_len    = (wr_idx >= MAX_LEN) ? MAX_LEN : wr_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_act_q  <= 1'b0;
      trunc_q   <= 1'b0;
      wr_slot_q <= '0;
      wcnt_q    <= '0;
    end else if (wr_accept) begin
      in_act_q  <= ~in_eop;
      wr_slot_q <= wr_slot;
      wcnt_q    <= wr_en ? wr_idx + 1'b1 : wr_idx;
      trunc_q   <= (in_sop ? 1'b0 : trunc_q) | ~wr_en;
    end
  end

  // Simple dual-port slot memory, registered read
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_slot, wr_idx[WORD_W-1:0]}] <= in_data;
    rd_data_q <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  pkt_release_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMDQ_D)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pktIDout_valid),
    .wdata (pktIDout),
    .pop   (cmd_pop),
    .q     (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  always_comb begin
    cmd_pop    = (state_q == POP);
    ovf_err    = pktIDout_valid & cmd_full & ~cmd_pop;
    head_slot  = cmd_head[CMD_ID_LSB +: SLOT_W];
    head_act   = cmd_act(cmd_head);
    head_ok    = slot_valid_q[head_slot];
    head_sends = (head_act == ACT_SEND) | (head_act == ACT_COPY);
    pop_start  = cmd_pop & head_ok & head_sends;
    pop_free   = cmd_pop & head_ok & ~head_sends;
    miss_err   = cmd_pop & ~head_ok;
  end

  // ---------------------------------------------------------------------------
  // Egress pipeline: read register -> skid -> output register. A read is only
  // issued when the skid is guaranteed free for it, so no read is ever lost.
  always_comb begin
    out_fire    = out_valid & out_ready;
    out_load    = ~out_valid | out_ready;
    eop_done    = (state_q == SEND) & out_fire & out_eop;
    rd_issue_ok = ~skid_valid_q & ~(rd_vld_q & ~out_load);
    send_issue  = (state_q == SEND) & (rcnt_q < cur_len_q) & rd_issue_ok;
    issue       = pop_start | send_issue;
    issue_idx   = pop_start ? '0 : rcnt_q;
    issue_slot  = pop_start ? head_slot : cur_slot_q;
    issue_len   = pop_start ? len_q[head_slot] : cur_len_q;
    issue_sop   = (issue_idx == '0);
    issue_eop   = (issue_idx == issue_len - 1'b1);
    rd_addr     = {issue_slot, issue_idx[WORD_W-1:0]};
  end

  // Ingress set is applied after any free so a same-cycle eop keeps the slot valid
  always_comb begin
    free_en   = pop_free | (eop_done & (cur_act_q != ACT_COPY));
    free_slot = pop_free ? head_slot : cur_slot_q;
    slot_valid_d = slot_valid_q;
    if (free_en) slot_valid_d[free_slot] = 1'b0;
    if (wr_done) slot_valid_d[wr_slot]   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= '0;
      for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      if (wr_done) len_q[wr_slot] <= wr_len;
    end
  end

  // ---------------------------------------------------------------------------
  // Release FSM with registered egress outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_act_q    <= ACT_SEND;
      cur_slot_q   <= '0;
      cur_len_q    <= '0;
      rcnt_q       <= '0;
      rd_vld_q     <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      skid_data_q  <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
    end else begin
      rd_vld_q <= issue;
      if (issue) begin
        rd_sop_q <= issue_sop;
        rd_eop_q <= issue_eop;
      end

      if (out_load) begin
        if (skid_valid_q) begin
          out_valid    <= 1'b1;
          out_sop      <= skid_sop_q;
          out_eop      <= skid_eop_q;
          out_data     <= skid_data_q;
          skid_valid_q <= rd_vld_q;
          skid_sop_q   <= rd_sop_q;
          skid_eop_q   <= rd_eop_q;
          skid_data_q  <= rd_data_q;
        end else if (rd_vld_q) begin
          out_valid <= 1'b1;
          out_sop   <= rd_sop_q;
          out_eop   <= rd_eop_q;
          out_data  <= rd_data_q;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_vld_q) begin
        skid_valid_q <= 1'b1;
        skid_sop_q   <= rd_sop_q;
        skid_eop_q   <= rd_eop_q;
        skid_data_q  <= rd_data_q;
      end

      case (state_q)
        IDLE: if (!cmd_empty) state_q <= POP;
        POP: begin
          if (pop_start) begin
            state_q    <= SEND;
            cur_act_q  <= head_act;
            cur_slot_q <= head_slot;
            cur_len_q  <= len_q[head_slot];
            rcnt_q     <= LEN_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        SEND: begin
          if (send_issue) rcnt_q <= rcnt_q + 1'b1;
          if (eop_done)   state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter; several error sources may fire in one cycle
  always_comb begin
    err_inc = 2'(trunc_err) + 2'(ovf_err) + 2'(miss_err);
    err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_cnt = err_cnt_q;
  assign busy    = (state_q != IDLE) | ~cmd_empty;

endmodule

// File: tb/tb_pkt_release.sv
// Directed self-checking bench for pkt_release: send, drop, copy, backpressure,
// command overflow, truncation and mid-send reset.
module tb_pkt_release;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_sop, in_eop;
  logic [7:0]   in_id;
  logic [127:0] in_data;
  logic         pktIDout_valid;
  logic [11:0]  pktIDout;
  logic         out_valid, out_sop, out_eop;
  logic [127:0] out_data;
  logic         out_ready;
  logic         busy;
  logic [15:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_release dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_id          (in_id),
    .in_data        (in_data),
    .pktIDout_valid (pktIDout_valid),
    .pktIDout       (pktIDout),
    .out_valid      (out_valid),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy),
    .err_cnt        (err_cnt)
  );

  function automatic logic [127:0] word(input logic [31:0] base, input int i);
    logic [31:0] w;
    w = base + 32'(i);
    return {w, w, w, w};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 0; in_sop = 0; in_eop = 0; in_id = '0; in_data = '0;
    pktIDout_valid = 0; pktIDout = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic ingress(input logic [7:0] id, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == n - 1);
      in_id = id; in_data = word(base, i);
    end
    @(negedge clk);
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic push_cmd(input logic [11:0] c);
    @(negedge clk);
    pktIDout_valid = 1'b1; pktIDout = c;
    @(negedge clk);
    pktIDout_valid = 1'b0;
  endtask

  task automatic watch(input int cyc, output bit seen);
    seen = 0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
  endtask

  // Accept len words of one packet; toggle alternates out_ready each cycle.
  task automatic collect_pkt(input logic [31:0] base, input int len, input bit toggle,
                             input string name);
    int got = 0;
    int cyc = 0;
    bit rdy = 1'b1;
    bit stalled = 1'b0;
    logic [127:0] held = '0;
    while (got < len && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL %s stall word %0d: valid %b data %h, required valid 1 data %h",
                   name, got, out_valid, out_data, held);
        end
      end
      rdy = toggle ? ~rdy : 1'b1;
      out_ready = rdy;
      stalled = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          checks++;
          if ({out_sop, out_eop, out_data} !== {(got == 0), (got == len - 1), word(base, got)}) begin
            errors++;
            $display("FAIL %s word %0d: sop %b eop %b data %h, required sop %b eop %b data %h",
                     name, got, out_sop, out_eop, out_data, (got == 0), (got == len - 1),
                     word(base, got));
          end
          got++;
        end else begin
          held = out_data;
          stalled = 1'b1;
        end
      end
    end
    out_ready = 1'b1;
    checks++;
    if (got != len) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, got, len);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_sop, out_eop, busy} !== 4'b0000 || out_data !== '0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: valid %b sop %b eop %b busy %b data %h err %0d, required all zero",
               out_valid, out_sop, out_eop, busy, out_data, err_cnt);
    end
  endtask

  task automatic test_send();
    bit seen;
    do_reset();
    out_ready = 1'b0;
    ingress(8'h05, 3, 32'h5000_0000);
    push_cmd(12'h005);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL send busy: got %b, required 1", busy);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL send latency early cycle %0d: valid %b, required 0", k, out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sop !== 1'b1) begin
      errors++; $display("FAIL send latency: valid %b sop %b, required 1 1", out_valid, out_sop);
    end
    collect_pkt(32'h5000_0000, 3, 1'b0, "send");
    push_cmd(12'h005);
    watch(12, seen);
    checks++;
    if (seen || err_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL send freed: out seen %b err %0d busy %b, required 0 1 0", seen, err_cnt, busy);
    end
  endtask

  task automatic test_drop();
    bit seen;
    do_reset();
    ingress(8'h07, 2, 32'h7000_0000);
    push_cmd(12'h107);
    watch(10, seen);
    checks++;
    if (seen || err_cnt !== 16'd0) begin
      errors++; $display("FAIL drop: out seen %b err %0d, required 0 0", seen, err_cnt);
    end
    push_cmd(12'h007);
    watch(10, seen);
    checks++;
    if (seen || err_cnt !== 16'd1) begin
      errors++; $display("FAIL drop freed: out seen %b err %0d, required 0 1", seen, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    do_reset();
    ingress(8'h02, 3, 32'h2000_0000);
    @(negedge clk); pktIDout_valid = 1'b1; pktIDout = 12'h202;
    @(negedge clk); pktIDout = 12'h002;
    @(negedge clk); pktIDout_valid = 1'b0;
    collect_pkt(32'h2000_0000, 3, 1'b0, "copy1");
    collect_pkt(32'h2000_0000, 3, 1'b0, "copy2");
    push_cmd(12'h002);
    watch(10, seen);
    checks++;
    if (seen || err_cnt !== 16'd1) begin
      errors++; $display("FAIL copy freed: out seen %b err %0d, required 0 1", seen, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ingress(8'h0A, 4, 32'hA000_0000);
    push_cmd(12'h00A);
    collect_pkt(32'hA000_0000, 4, 1'b1, "toggle");
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL toggle end: busy %b valid %b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_cmd_overflow();
    bit seen;
    int cyc;
    logic [11:0] cmds [6];
    cmds = '{12'h203, 12'h004, 12'h003, 12'h106, 12'h005, 12'h005};
    do_reset();
    ingress(8'h01, 2, 32'h1000_0000);
    ingress(8'h03, 2, 32'h3000_0000);
    ingress(8'h04, 3, 32'h4000_0000);
    ingress(8'h06, 1, 32'h6000_0000);
    out_ready = 1'b0;
    push_cmd(12'h001);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL overflow stall: valid %b, required 1", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pktIDout_valid = 1'b1; pktIDout = cmds[i];
    end
    @(negedge clk);
    pktIDout_valid = 1'b0;
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++; $display("FAIL overflow count: err %0d, required 2", err_cnt);
    end
    collect_pkt(32'h1000_0000, 2, 1'b0, "ovf slot1");
    collect_pkt(32'h3000_0000, 2, 1'b0, "ovf slot3 copy");
    collect_pkt(32'h4000_0000, 3, 1'b0, "ovf slot4");
    collect_pkt(32'h3000_0000, 2, 1'b0, "ovf slot3 send");
    watch(12, seen);
    checks++;
    if (seen || err_cnt !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow end: out seen %b err %0d busy %b, required 0 2 0", seen, err_cnt, busy);
    end
  endtask

  task automatic test_truncate_reset();
    bit seen;
    int cyc;
    do_reset();
    ingress(8'h09, 40, 32'h9000_0000);
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++; $display("FAIL truncate count: err %0d, required 1", err_cnt);
    end
    push_cmd(12'h209);
    collect_pkt(32'h9000_0000, 32, 1'b0, "truncate");
    push_cmd(12'h009);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL mid-send precondition: valid %b, required 1", out_valid);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid-send reset: valid %b busy %b err %0d, required 0 0 0", out_valid, busy, err_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    push_cmd(12'h009);
    watch(10, seen);
    checks++;
    if (seen || err_cnt !== 16'd1) begin
      errors++; $display("FAIL slots after reset: out seen %b err %0d, required 0 1", seen, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_send();
    test_drop();
    test_back_to_back();
    test_backpressure();
    test_cmd_overflow();
    test_truncate_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
